// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1-style TAP controller for the JTAG pins.
// Holds the 16-state TAP FSM, an IR_WIDTH instruction register, the BYPASS
// and IDCODE data registers, and NUM_USER_DR user data registers that the
// debug logic reads and writes through parallel capture/update ports.
//
// Ports:
//   clk               TCK; every state change happens on its rising edge
//   reset_n           asynchronous active-low reset (TRST equivalent)
//   tms, tdi          test mode select / serial data in
//   tdo, tdo_en       serial data out and its enable (Shift-DR / Shift-IR)
//   tap_state         current FSM state, 4-bit encoding below
//   ir_value          current (updated) instruction
//   user_capture_data parallel values loaded in Capture-DR, slice i = DR i
//   user_update_data  update registers, slice i = DR i
//   user_update_pulse one-cycle strobe per user DR after Update-DR
module jtag_tap_ctrl #(
    parameter int                  IR_WIDTH        = 4,
    parameter logic [31:0]         IDCODE_VALUE    = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] IDCODE_INSTR    = 4'b0001,
    parameter logic [IR_WIDTH-1:0] USER_BASE_INSTR = 4'b1000,
    parameter int                  NUM_USER_DR     = 2,
    parameter int                  USER_DR_WIDTH   = 32
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   tms,
    input  logic                                   tdi,
    output logic                                   tdo,
    output logic                                   tdo_en,
    output logic [3:0]                             tap_state,
    output logic [IR_WIDTH-1:0]                    ir_value,
    input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_capture_data,
    output logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_update_data,
    output logic [NUM_USER_DR-1:0]                 user_update_pulse
);

    localparam logic [3:0] TLR    = 4'h0;
    localparam logic [3:0] RTI    = 4'h1;
    localparam logic [3:0] SEL_DR = 4'h2;
    localparam logic [3:0] CAP_DR = 4'h3;
    localparam logic [3:0] SH_DR  = 4'h4;
    localparam logic [3:0] EX1_DR = 4'h5;
    localparam logic [3:0] PAU_DR = 4'h6;
    localparam logic [3:0] EX2_DR = 4'h7;
    localparam logic [3:0] UPD_DR = 4'h8;
    localparam logic [3:0] SEL_IR = 4'h9;
    localparam logic [3:0] CAP_IR = 4'hA;
    localparam logic [3:0] SH_IR  = 4'hB;
    localparam logic [3:0] EX1_IR = 4'hC;
    localparam logic [3:0] PAU_IR = 4'hD;
    localparam logic [3:0] EX2_IR = 4'hE;
    localparam logic [3:0] UPD_IR = 4'hF;

    // Parameter sanity: reject configurations that would make opcode decode
    // ambiguous or break the IDCODE/BYPASS discovery convention.
    if (IR_WIDTH < 2) begin : g_err_irw
        $error("jtag_tap_ctrl: IR_WIDTH must be at least 2");
    end
    if (IDCODE_VALUE[0] != 1'b1) begin : g_err_idcode
        $error("jtag_tap_ctrl: IDCODE_VALUE bit 0 must be 1");
    end
    if (NUM_USER_DR < 1 || NUM_USER_DR > 4) begin : g_err_num
        $error("jtag_tap_ctrl: NUM_USER_DR must be 1..4");
    end
    for (genvar gi = 0; gi < NUM_USER_DR; gi++) begin : g_op_chk
        localparam logic [IR_WIDTH-1:0] OP = USER_BASE_INSTR + IR_WIDTH'(gi);
        if (OP == IDCODE_INSTR || OP == {IR_WIDTH{1'b1}}) begin : g_err_op
            $error("jtag_tap_ctrl: user opcode collides with IDCODE or BYPASS");
        end
    end

    logic [3:0]               state;
    logic [3:0]               next_state;
    logic [IR_WIDTH-1:0]      ir_sr;
    logic [31:0]              idcode_sr;
    logic                     bypass_sr;
    logic [USER_DR_WIDTH-1:0] user_sr  [NUM_USER_DR];
    logic [USER_DR_WIDTH-1:0] user_cap [NUM_USER_DR];
    logic [USER_DR_WIDTH-1:0] user_upd [NUM_USER_DR];
    logic                     sel_idcode;
    logic                     sel_bypass;
    logic [NUM_USER_DR-1:0]   sel_user;
    logic                     dr_bit;

    // Unpack the flat parallel ports into per-DR arrays.
    for (genvar gi = 0; gi < NUM_USER_DR; gi++) begin : g_user_io
        assign user_cap[gi] = user_capture_data[gi*USER_DR_WIDTH +: USER_DR_WIDTH];
        assign user_update_data[gi*USER_DR_WIDTH +: USER_DR_WIDTH] = user_upd[gi];
    end

    assign tap_state = state;

    // DR selection follows only the updated instruction, never the IR shifter.
    always_comb begin
        sel_idcode = (ir_value == IDCODE_INSTR);
        sel_user   = '0;
        for (int i = 0; i < NUM_USER_DR; i++) begin
            sel_user[i] = (ir_value == USER_BASE_INSTR + IR_WIDTH'(i));
        end
        sel_bypass = !sel_idcode && (sel_user == '0);
    end

    always_comb begin
        case (state)
            TLR:     next_state = tms ? TLR    : RTI;
            RTI:     next_state = tms ? SEL_DR : RTI;
            SEL_DR:  next_state = tms ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = tms ? EX1_DR : SH_DR;
            SH_DR:   next_state = tms ? EX1_DR : SH_DR;
            EX1_DR:  next_state = tms ? UPD_DR : PAU_DR;
            PAU_DR:  next_state = tms ? EX2_DR : PAU_DR;
            EX2_DR:  next_state = tms ? UPD_DR : SH_DR;
            UPD_DR:  next_state = tms ? SEL_DR : RTI;
            SEL_IR:  next_state = tms ? TLR    : CAP_IR;
            CAP_IR:  next_state = tms ? EX1_IR : SH_IR;
            SH_IR:   next_state = tms ? EX1_IR : SH_IR;
            EX1_IR:  next_state = tms ? UPD_IR : PAU_IR;
            PAU_IR:  next_state = tms ? EX2_IR : PAU_IR;
            EX2_IR:  next_state = tms ? UPD_IR : SH_IR;
            UPD_IR:  next_state = tms ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    // Instruction register: capture 01, shift LSB-out, update on Update-IR.
    // Any transition into Test-Logic-Reset restores the IDCODE instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_sr    <= IDCODE_INSTR;
            ir_value <= IDCODE_INSTR;
        end else begin
            if (state == CAP_IR) begin
                ir_sr <= IR_WIDTH'(2'b01);
            end else if (state == SH_IR) begin
                ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
            end
            if (next_state == TLR) begin
                ir_value <= IDCODE_INSTR;
            end else if (state == UPD_IR) begin
                ir_value <= ir_sr;
            end
        end
    end

    // Data registers: only the selected DR captures or shifts; the others
    // hold, which also gives Pause-DR its hold behaviour for free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idcode_sr <= '0;
            bypass_sr <= 1'b0;
            for (int i = 0; i < NUM_USER_DR; i++) begin
                user_sr[i] <= '0;
            end
        end else if (state == CAP_DR) begin
            if (sel_idcode) idcode_sr <= IDCODE_VALUE;
            if (sel_bypass) bypass_sr <= 1'b0;
            for (int i = 0; i < NUM_USER_DR; i++) begin
                if (sel_user[i]) user_sr[i] <= user_cap[i];
            end
        end else if (state == SH_DR) begin
            if (sel_idcode) idcode_sr <= {tdi, idcode_sr[31:1]};
            if (sel_bypass) bypass_sr <= tdi;
            for (int i = 0; i < NUM_USER_DR; i++) begin
                if (sel_user[i]) user_sr[i] <= {tdi, user_sr[i][USER_DR_WIDTH-1:1]};
            end
        end
    end

    // Update side: only user DRs have one; the strobe lasts one TCK cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            user_update_pulse <= '0;
            for (int i = 0; i < NUM_USER_DR; i++) begin
                user_upd[i] <= '0;
            end
        end else begin
            user_update_pulse <= (state == UPD_DR) ? sel_user : '0;
            for (int i = 0; i < NUM_USER_DR; i++) begin
                if (state == UPD_DR && sel_user[i]) user_upd[i] <= user_sr[i];
            end
        end
    end

    // tdo is combinational from registered state so the first bit is
    // presented before the first shift edge.
    always_comb begin
        dr_bit = bypass_sr;
        if (sel_idcode) dr_bit = idcode_sr[0];
        for (int i = 0; i < NUM_USER_DR; i++) begin
            if (sel_user[i]) dr_bit = user_sr[i][0];
        end
        tdo    = 1'b0;
        tdo_en = 1'b0;
        if (state == SH_IR) begin
            tdo    = ir_sr[0];
            tdo_en = 1'b1;
        end else if (state == SH_DR) begin
            tdo    = dr_bit;
            tdo_en = 1'b1;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed self-checking bench for jtag_tap_ctrl with default parameters.
module tb_jtag_tap_ctrl;

    localparam int IRW = 4;
    localparam int NU  = 2;
    localparam int UW  = 32;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           tms;
    logic           tdi;
    logic           tdo;
    logic           tdo_en;
    logic [3:0]     tap_state;
    logic [IRW-1:0] ir_value;
    logic [NU*UW-1:0] ucap;
    logic [NU*UW-1:0] uupd;
    logic [NU-1:0]  upulse;

    int vectors     = 0;
    int miscompares = 0;
    bit tg          = 1'b0;

    logic [7:0] path_bits [16];
    int         path_len  [16];

    always #5 clk = ~clk;

    jtag_tap_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .tms               (tms),
        .tdi               (tdi),
        .tdo               (tdo),
        .tdo_en            (tdo_en),
        .tap_state         (tap_state),
        .ir_value          (ir_value),
        .user_capture_data (ucap),
        .user_update_data  (uupd),
        .user_update_pulse (upulse)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One TCK edge; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        #1;
    endtask

    // RTI -> Shift-IR, shift v LSB first, Update-IR, back to RTI.
    task automatic shift_ir(input logic [IRW-1:0] v, output logic [IRW-1:0] o);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < IRW; i++) begin
            o[i] = tdo;
            tick(i == IRW - 1, v[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // RTI -> Shift-DR, shift 32 bits (optionally via Pause-DR halfway),
    // Update-DR, back to RTI with the update edge just taken.
    task automatic shift_dr32(input logic [31:0] v, output logic [31:0] o, input bit pause_mid);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("shdr_tdo_en", 64'(tdo_en), 64'd1);
        for (int i = 0; i < 32; i++) begin
            o[i] = tdo;
            tick((i == 31) || (pause_mid && i == 15), v[i]);
            if (pause_mid && i == 15) begin
                tg = ~tg;
                tick(1'b0, tg);
                check("pause_state", 64'(tap_state), 64'h6);
                tg = ~tg;
                tick(1'b0, tg);
                tg = ~tg;
                tick(1'b1, tg);
                tick(1'b0, ~tg);
            end
        end
        check("exit1dr_state", 64'(tap_state), 64'h5);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]    o32;
        logic [IRW-1:0] o4;
        logic [3:0]     obits;
        logic [3:0]     bp;

        path_bits = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                      8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
        path_len  = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

        reset_n = 1'b0;
        tms     = 1'b1;
        tdi     = 1'b0;
        ucap    = {32'h1234_5678, 32'hA5A5_0F0F};
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",  64'(tap_state), 64'h0);
        check("rst_ir",     64'(ir_value),  64'h1);
        check("rst_tdo",    64'(tdo),       64'h0);
        check("rst_tdo_en", 64'(tdo_en),    64'h0);
        check("rst_upd",    64'(uupd),      64'h0);
        check("rst_pulse",  64'(upulse),    64'h0);

        reset_n = 1'b1;
        tick(1'b0, 1'b0);
        check("rti_state", 64'(tap_state), 64'h1);

        // IDCODE read straight after reset.
        shift_dr32(32'hCAFE_F00D, o32, 1'b0);
        check("idcode_read", 64'(o32), 64'h1000_0001);
        check("idcode_no_pulse", 64'(upulse), 64'h0);

        // Reach every state from TLR, then five tms=1 edges must return to TLR.
        for (int s = 0; s < 16; s++) begin
            repeat (5) begin
                tg = ~tg;
                tick(1'b1, tg);
            end
            for (int k = 0; k < path_len[s]; k++) begin
                tg = ~tg;
                tick(path_bits[s][k], tg);
            end
            check("path_state", 64'(tap_state), 64'(s));
            repeat (5) begin
                tg = ~tg;
                tick(1'b1, tg);
            end
            check("five_ones_state", 64'(tap_state), 64'h0);
            check("five_ones_ir",    64'(ir_value),  64'h1);
        end
        tick(1'b0, 1'b0);

        // BYPASS: IR all ones, shift 1,0,1,1 through the 1-bit register.
        shift_ir(4'hF, o4);
        check("ir_capture_bits", 64'(o4), 64'h1);
        check("ir_bypass", 64'(ir_value), 64'hF);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        bp = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            obits[k] = tdo;
            tick(k == 3, bp[k]);
        end
        check("bypass_tdo", 64'(obits), 64'hA);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("bypass_no_pulse", 64'(upulse), 64'h0);
        check("bypass_no_upd",   64'(uupd),   64'h0);

        // User DR 0 with a Pause-DR excursion mid-shift.
        shift_ir(4'h8, o4);
        check("ir_capture_bits2", 64'(o4), 64'h1);
        check("ir_user0", 64'(ir_value), 64'h8);
        shift_dr32(32'hDEAD_BEEF, o32, 1'b1);
        check("user0_capture", 64'(o32), 64'hA5A5_0F0F);
        check("user0_update",  64'(uupd), 64'h0000_0000_DEAD_BEEF);
        check("user0_pulse",   64'(upulse), 64'h1);
        tick(1'b0, 1'b0);
        check("user0_pulse_end", 64'(upulse), 64'h0);
        check("user0_update_hold", 64'(uupd), 64'h0000_0000_DEAD_BEEF);

        // User DR 1.
        shift_ir(4'h9, o4);
        check("ir_user1", 64'(ir_value), 64'h9);
        shift_dr32(32'h0BAD_F00D, o32, 1'b0);
        check("user1_capture", 64'(o32), 64'h1234_5678);
        check("user1_update",  64'(uupd), 64'h0BAD_F00D_DEAD_BEEF);
        check("user1_pulse",   64'(upulse), 64'h2);
        tick(1'b0, 1'b0);
        check("user1_pulse_end", 64'(upulse), 64'h0);

        // Reset asserted in the middle of a user DR shift.
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b1);
        check("midshift_state", 64'(tap_state), 64'h4);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_state",  64'(tap_state), 64'h0);
        check("midrst_tdo_en", 64'(tdo_en),    64'h0);
        check("midrst_tdo",    64'(tdo),       64'h0);
        check("midrst_ir",     64'(ir_value),  64'h1);
        check("midrst_upd",    64'(uupd),      64'h0);
        check("midrst_pulse",  64'(upulse),    64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midrst_pulse2", 64'(upulse), 64'h0);
        reset_n = 1'b1;
        tick(1'b0, 1'b0);
        shift_dr32(32'h0, o32, 1'b0);
        check("idcode_after_rst", 64'(o32), 64'h1000_0001);
        check("upd_after_rst",    64'(uupd), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
Complete, parametrised IEEE 1149.1-style TAP controller and the successor to the bare TAP state machine. It contains the 16-state TAP FSM driven by TMS, a parametrised instruction register, and BYPASS and IDCODE data registers. It also provides NUM_USER_DR user data registers with parallel capture and update ports for the debug logic. The block sits at the JTAG pins; clk is TCK.

Parameters:
IR_WIDTH, 4, instruction register width (min 2)
IDCODE_VALUE, 32'h1000_0001, value captured into the IDCODE DR (bit 0 must be 1)
IDCODE_INSTR, 4'b0001, opcode selecting the IDCODE DR; also the IR reset value
USER_BASE_INSTR, 4'b1000, opcode of user DR 0; user DR i uses USER_BASE_INSTR+i
NUM_USER_DR, 2, number of user data registers (1..4)
USER_DR_WIDTH, 32, width of each user DR

Ports:
clk  in  1  TCK; all state changes on the rising edge
reset_n  in  1  asynchronous, active-low reset (TRST equivalent)
tms  in  1  test mode select; drives FSM transitions
tdi  in  1  serial data in
tdo  out  1  serial data out
tdo_en  out  1  high while in Shift-DR or Shift-IR
tap_state  out  4  current FSM state (encoding below)
ir_value  out  IR_WIDTH  current updated instruction
user_capture_data  in  NUM_USER_DR*USER_DR_WIDTH  parallel values loaded in Capture-DR; slice i belongs to DR i
user_update_data  out  NUM_USER_DR*USER_DR_WIDTH  update registers; slice i belongs to DR i
user_update_pulse  out  NUM_USER_DR  one-cycle strobe per DR after Update-DR

Behaviour:
- Reset (reset_n low, asynchronous):
  - tap_state = Test-Logic-Reset.
  - ir_value = IDCODE_INSTR; IR shift register = IDCODE_INSTR.
  - All DR shift registers = 0; user_update_data = 0; user_update_pulse = 0.
  - tdo = 0; tdo_en = 0.
- State encoding: TLR 0, RTI 1, SelDR 2, CapDR 3, ShDR 4, Ex1DR 5, PauDR 6, Ex2DR 7, UpdDR 8, SelIR 9, CapIR A, ShIR B, Ex1IR C, PauIR D, Ex2IR E, UpdIR F.
- Transitions follow the standard TAP graph, sampled on tms at each rising edge. tdi must not affect state.
- Five consecutive tms=1 edges reach TLR from any state.
- Entering TLR by transition loads ir_value = IDCODE_INSTR on that same edge.
- Fully synchronous next-state logic; complete case with default to TLR.
- DR selection by ir_value:
  - IDCODE_INSTR selects the 32-bit IDCODE DR.
  - USER_BASE_INSTR+i (i < NUM_USER_DR) selects user DR i.
  - All-ones and every other opcode select the 1-bit BYPASS DR.
- All register actions occur on the rising edge while tap_state equals the named state:
  - CapIR: IR shift register = {zeros, 2'b01}.
  - ShIR: IR shift register shifts right; tdi enters the MSB.
  - UpdIR: ir_value = IR shift register.
  - CapDR: selected DR loads its capture value: IDCODE_VALUE, user_capture_data slice, or 0 for BYPASS.
  - ShDR: selected DR shifts right, tdi into MSB; unselected DRs hold.
  - UpdDR: for user DR i selected, user_update_data slice i = shift register; user_update_pulse[i] = 1 for exactly the following cycle. BYPASS and IDCODE have no update side effect.
- tdo and tdo_en are combinational from registered state, with no extra latency:
  - In ShIR: tdo = IR shift register bit 0.
  - In ShDR: tdo = selected DR bit 0.
  - Otherwise tdo = 0; tdo_en = 1 only in ShDR/ShIR.
  - The first bit is visible while in the shift state, before the first shift edge.
- Selection is fixed by ir_value. Instructions shifted but not yet updated have no effect.
- PauDR/PauIR hold all shift registers. Ex2 -> Shift resumes shifting where it stopped.
- Reset mid-shift: all registers and outputs return to reset values immediately, with no update pulse. Partially shifted data is discarded.
- Opcode arithmetic USER_BASE_INSTR+i is IR_WIDTH wide. Elaboration fails if any user opcode collides with IDCODE_INSTR or all-ones.

Test Plan:
- Release reset_n; tms=0 for one edge (-> RTI); tms 1,0,0 -> ShDR; clock 32 edges with tms=1 on the last -> tdo sequence LSB-first equals 32'h1000_0001; tap_state = 5 after the final edge.
- From each of the 16 states, apply five tms=1 edges -> tap_state = 0 and ir_value = IDCODE_INSTR; tdi toggling never alters the path.
- Shift IR = 4'b1111 (BYPASS); in ShDR shift the pattern 1,0,1,1 -> tdo shows 0,1,0,1 (one-cycle delay, captured 0 first).
- Enter ShIR -> the first two tdo bits read 1,0 (capture 01); shift 4'b1000 and pass UpdIR -> ir_value = 8.
- With IR=8 and user_capture_data[31:0]=32'hA5A5_0F0F: shift in 32'hDEAD_BEEF -> tdo reads 32'hA5A5_0F0F; after UpdDR, user_update_data[31:0]=32'hDEAD_BEEF and user_update_pulse=2'b01 for exactly one cycle; slice 1 unchanged.
- Assert reset_n low mid-ShDR after 10 bits -> tap_state=0, tdo_en=0, user_update_data unchanged at 0, no pulse; a subsequent IDCODE read returns 32'h1000_0001.
